dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter in front of the single-port data memory (Giga_D).
//  Port 0 is the CPU load/store unit. Port 1 is the loader/debug DMA port.
//  Each cycle the block grants at most one requester and drives Address, WriteData, MemRead and MemWrite.
//  It registers read data back to the winner. An optional lock holds ownership for short bursts.
// PARAMETERS
//  ADDR_W     32  byte address width; passed unchanged to memory (memory does the >>2 word indexing)
//  DATA_W     32  data width
//  MAX_BURST  4   max consecutive locked grants to one port before ownership must be re-arbitrated (>=1)
// PORTS
//  clk        in   1       system clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  p0_req     in   1       port 0 request; held with addr/we/wdata stable until p0_gnt
//  p0_we      in   1       1=write, 0=read
//  p0_lock    in   1       request to keep ownership for the next beat
//  p0_addr    in   ADDR_W  byte address
//  p0_wdata   in   DATA_W  write data
//  p0_gnt     out  1       combinational grant; beat completes at this posedge
//  p0_rvalid  out  1       registered; high for 1 cycle, the cycle after a granted read
//  p0_rdata   out  DATA_W  registered read data; holds last value otherwise
//  p1_*       --   --      identical set for port 1
//  mem_addr   out  ADDR_W  to Giga_D.Address
//  mem_wdata  out  DATA_W  to Giga_D.WriteData
//  mem_read   out  1       to Giga_D.MemRead
//  mem_write  out  1       to Giga_D.MemWrite
//  mem_rdata  in   DATA_W  from Giga_D.ReadData (combinational; Z when mem_read=0)
//  owner      out  2       debug: 00 none, 01 port0 locked, 10 port1 locked
// BEHAVIOUR
//  - FSM: IDLE, OWN0, OWN1. State is held in register `owner`.
//  - Reset (rst_n=0, async):
//    - state=IDLE, burst_cnt=0, last=1 (port 0 wins the first tie).
//    - p*_rvalid=0, p*_rdata=0.
//    - gnt, mem_read and mem_write are forced 0 combinationally while rst_n=0. No write can occur mid-reset.
//  - IDLE arbitration (same cycle):
//    - Only one requesting port: that port is granted.
//    - Both ports requesting: tie-break per CONFIGURATION.
//  - OWNx:
//    - The owner is granted whenever it requests. The other port is never granted.
//    - Owner drops req (req=0): return to IDLE without granting. The other port is arbitrated the following cycle.
//  - A granted beat with lock=1 and burst_cnt<MAX_BURST-1:
//    - next state OWNx; burst_cnt increments.
//  - Otherwise (lock=0, or burst_cnt==MAX_BURST-1):
//    - next state IDLE; burst_cnt=0.
//    - When the cap is reached, the winner's priority is lowered as for a normal grant.
//  - Memory drive:
//    - mem_addr/mem_wdata come from the granted port, else 0.
//    - mem_read = gnt & ~we; mem_write = gnt & we.
//  - Write: committed by memory at the grant posedge. No response; rvalid stays 0.
//  - Read: mem_rdata is sampled at the grant posedge into px_rdata. px_rvalid=1 for exactly the next cycle.
//    - Latency is 1 cycle. Back-to-back reads give rvalid on consecutive cycles.
//  - mem_rdata is never sampled when mem_read=0, so Z never reaches px_rdata.
//  - Simultaneous read (p0) and write (p1) to the same address: serialized. The first granted beat sees the pre-write or post-write value accordingly.
//  - Exactly one gnt at most per cycle (p0_gnt & p1_gnt == 0 always).
// CONFIGURATION
//  - DMEM_ARB_RR_EN defined:
//    - Round-robin. On an IDLE tie, the port not granted most recently (`last`) wins.
//    - `last` updates on every granted beat that ends ownership.
//  - DMEM_ARB_RR_EN undefined:
//    - Fixed priority. Port 0 always wins IDLE ties.
//    - Port 1 can starve; lock and MAX_BURST behaviour are unchanged.
// TESTING
//  1. Reset, then p0 write 0xDEADBEEF @0x10; next cycle p0 read @0x10 -> p0_gnt same cycle, p0_rvalid next cycle, p0_rdata=0xDEADBEEF.
//  2. p0 and p1 both read every cycle, lock=0, RR_EN on -> grants alternate p0,p1,p0,p1; with RR_EN off -> p0 every cycle, p1_gnt never.
//  3. p1 lock=1 continuous reads, MAX_BURST=4, p0 req -> p1 granted 4 beats, then p0 granted, owner 10->00.
//  4. p1 locked, drops req mid-burst with p0 pending -> 1 idle cycle (no gnt), then p0_gnt; burst_cnt back to 0.
//  5. Assert rst_n low mid p0 write beat -> mem_write=0 immediately, memory @addr unchanged, all rvalid=0, owner=00.
//  6. p1 writes 0x1234 @0x20 while p0 reads @0x20 same cycle (RR, last=p1) -> p0 granted first reads old value (0), then p1 write; next p0 read returns 0x1234.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory, with optional burst lock.
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             gnt0;
  logic             gnt1;
  logic             tie_pick1;
  logic             grant_lock;

`ifdef DMEM_ARB_RR_EN
  logic last;

  // Remember which port ended the most recent ownership; the other wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if ((gnt0 || gnt1) && !(grant_lock && burst_cnt < CNT_CAP)) begin
      last <= gnt1;
    end
  end

  assign tie_pick1 = ~last;
`else
  assign tie_pick1 = 1'b0;
`endif

  // Grant decode; grants are suppressed while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (p0_req && p1_req) begin
            gnt0 = ~tie_pick1;
            gnt1 = tie_pick1;
          end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
          end
        end
        OWN0:    gnt0 = p0_req;
        OWN1:    gnt1 = p1_req;
        default: ;
      endcase
    end
  end

  assign p0_gnt     = gnt0;
  assign p1_gnt     = gnt1;
  assign grant_lock = gnt0 ? p0_lock : p1_lock;

  assign mem_addr  = gnt0 ? p0_addr  : (gnt1 ? p1_addr  : '0);
  assign mem_wdata = gnt0 ? p0_wdata : (gnt1 ? p1_wdata : '0);
  assign mem_read  = (gnt0 & ~p0_we) | (gnt1 & ~p1_we);
  assign mem_write = (gnt0 &  p0_we) | (gnt1 &  p1_we);

  // Ownership FSM: a locked beat keeps the port until the burst cap or a dropped request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if (gnt0 || gnt1) begin
      if (grant_lock && burst_cnt < CNT_CAP) begin
        state     <= gnt0 ? OWN0 : OWN1;
        burst_cnt <= burst_cnt + CNT_W'(1);
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end else if (state != IDLE) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end
  end

  assign owner = state;

  // Read response: capture memory data only on a granted read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= gnt0 & ~p0_we;
      p1_rvalid <= gnt1 & ~p1_we;
      if (gnt0 && !p0_we) p0_rdata <= mem_rdata;
      if (gnt1 && !p1_we) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_BURST = 4;

  logic              clk;
  logic              rst_n;
  logic              req   [2];
  logic              we    [2];
  logic              lock  [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];

  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;
  logic [1:0]        owner;

  logic [DATA_W-1:0] tb_mem  [16];
  logic [DATA_W-1:0] ref_mem [16];

  int                n_tests = 0;
  int                n_fail  = 0;

  // Model state: who holds a lock (-1 none), beats in the current hold, last port to end ownership
  int                hold;
  int                streak;
  int                last_w;
  logic              exp_rv [2];
  logic [DATA_W-1:0] exp_rd [2];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lock[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lock[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Giga_D: combinational read, write at posedge; junk when not reading
  assign mem_rdata = mem_read ? tb_mem[mem_addr[5:2]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[5:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int predict();
    if (hold == 0) return req[0] ? 0 : -1;
    if (hold == 1) return req[1] ? 1 : -1;
    if (req[0] && req[1]) begin
`ifdef DMEM_ARB_RR_EN
      return (last_w == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    hold = -1; streak = 0; last_w = 1;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_rd[0] = '0;   exp_rd[1] = '0;
  endtask

  task automatic check_regs();
    logic [1:0] exp_owner;
    exp_owner = (hold < 0) ? 2'b00 : ((hold == 0) ? 2'b01 : 2'b10);
    check("p0_rvalid", p0_rvalid, exp_rv[0]);
    check("p1_rvalid", p1_rvalid, exp_rv[1]);
    check("p0_rdata", p0_rdata, exp_rd[0]);
    check("p1_rdata", p1_rdata, exp_rd[1]);
    check("owner", owner, exp_owner);
  endtask

  // One clock: check grant/memory drive before the edge, then response and ownership after it.
  task automatic cycle(output int w);
    logic exp_rd_c, exp_wr_c;
    int   idx;
    #1;
    w = predict();
    exp_rd_c = 1'b0;
    exp_wr_c = 1'b0;
    if (w >= 0) begin
      exp_rd_c = ~we[w];
      exp_wr_c = we[w];
    end
    check("p0_gnt", p0_gnt, w == 0);
    check("p1_gnt", p1_gnt, w == 1);
    check("mem_read", mem_read, exp_rd_c);
    check("mem_write", mem_write, exp_wr_c);
    if (w >= 0) begin
      check("mem_addr", mem_addr, addr[w]);
      if (we[w]) check("mem_wdata", mem_wdata, wdata[w]);
    end else begin
      check("mem_addr_idle", mem_addr, 0);
    end
    @(posedge clk);
    #1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (w >= 0) begin
      idx = int'(addr[w][5:2]);
      if (!we[w]) begin
        exp_rv[w] = 1'b1;
        exp_rd[w] = ref_mem[idx];
      end else begin
        ref_mem[idx] = wdata[w];
      end
      if (lock[w] && (streak + 1) < MAX_BURST) begin
        hold = w;
        streak = streak + 1;
      end else begin
        hold = -1;
        streak = 0;
        last_w = w;
      end
      req[w] = 1'b0;
    end else if (hold >= 0) begin
      hold = -1;
      streak = 0;
    end
    check_regs();
  endtask

  initial begin
    int w;
    int n1;
    bit p0_done;

    for (int i = 0; i < 16; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; lock[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
    end
    model_reset();

    // Reset with a write pending: nothing may be granted
    rst_n = 1'b0;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", p0_gnt, 0);
    check("rst_mem_write", mem_write, 0);
    check_regs();
    #3 rst_n = 1'b1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mem_untouched", tb_mem[2], 0);

    // Write then read back on port 0
    req[0] = 1'b1; we[0] = 1'b1; lock[0] = 1'b0; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
    cycle(w);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    cycle(w);
    check("t1_readback", p0_rdata, 32'hDEAD_BEEF);

    // Port 1 locked burst is capped, then port 0 gets in
    req[1] = 1'b1; we[1] = 1'b0; lock[1] = 1'b1; addr[1] = 32'h3C;
    cycle(w);
    n1 = (w == 1) ? 1 : 0;
    req[0] = 1'b1; we[0] = 1'b0; lock[0] = 1'b0; addr[0] = 32'h44;
    p0_done = 1'b0;
    for (int i = 0; i < 8 && !p0_done; i++) begin
      req[1] = 1'b1;
      cycle(w);
      if (w == 1) n1++;
      if (w == 0) p0_done = 1'b1;
    end
    check("burst_len", n1, MAX_BURST);
    check("p0_after_burst", p0_done, 1);
    req[0] = 1'b0; req[1] = 1'b0;
    cycle(w);

    // Reset asserted in the middle of a granted write beat
    req[0] = 1'b1; we[0] = 1'b1; lock[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'hCAFE_F00D;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_gnt", p0_gnt, 0);
    check("midrst_mem_write", mem_write, 0);
    check_regs();
    @(posedge clk);
    #1;
    check("midrst_mem_kept", tb_mem[5], ref_mem[5]);
    req[0] = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 3) != 0) begin
          req[p]   = 1'b1;
          we[p]    = 1'($urandom_range(0, 1));
          lock[p]  = 1'($urandom_range(0, 1));
          addr[p]  = ADDR_W'($urandom_range(0, 15)) << 2;
          wdata[p] = DATA_W'($urandom());
        end
      end
      cycle(w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
